// File: rtl/onehot_rr_arbiter_pkg.sv
// Shared definitions for the one-hot round-robin arbiter.
package onehot_rr_arbiter_pkg;

    // Largest requester count the arbiter is built for.
    localparam int unsigned MaxNr = 16;

    // Output slot state: IDLE holds nothing, FULL holds one accepted payload.
    typedef enum logic {
        StIdle = 1'b0,
        StFull = 1'b1
    } arb_state_e;

endpackage

// File: rtl/onehot_rr_arbiter_mux.sv
// AND-OR one-hot multiplexer: selects one W-bit slice of a packed bus.
module onehot_rr_arbiter_mux #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic [N-1:0]   i_sel,
    input  logic [N*W-1:0] i_data,
    output logic [W-1:0]   o_data
);

    // OR together every slice gated by its select bit; all-zero select gives zero.
    always_comb begin
        o_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            o_data = o_data | (i_data[i*W +: W] & {W{i_sel[i]}});
        end
    end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter feeding a single registered output slot with one-hot grant.
module onehot_rr_arbiter
    import onehot_rr_arbiter_pkg::*;
#(
    parameter int unsigned NR = 4,
    parameter int unsigned DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NR-1:0]   req_valid,
    output logic [NR-1:0]   req_ready,
    input  logic [NR*DW-1:0] req_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [NR-1:0]   grant
);

    localparam int unsigned PtrW = $clog2(NR);

    if (NR < 2 || NR > MaxNr) begin : g_bad_nr
        $error("onehot_rr_arbiter: NR out of supported range");
    end

    arb_state_e      r_state;
    arb_state_e      w_state_next;
    logic [PtrW-1:0] r_ptr;
    logic [PtrW-1:0] w_ptr_next;
    logic [DW-1:0]   r_data;
    logic [DW-1:0]   w_data_next;
    logic [NR-1:0]   r_grant;
    logic [NR-1:0]   w_grant_next;

    logic [NR-1:0]   w_winner_oh;
    logic [PtrW-1:0] w_winner_idx;
    logic [PtrW-1:0] w_scan_idx;
    logic            w_found;
    logic            w_slot_free;
    logic            w_accept;
    logic [DW-1:0]   w_mux_data;

    // Rotating priority scan: first valid requester at or after r_ptr, wrapping.
    always_comb begin
        w_winner_oh  = '0;
        w_winner_idx = '0;
        w_scan_idx   = '0;
        w_found      = 1'b0;
        for (int unsigned k = 0; k < NR; k++) begin
            w_scan_idx = PtrW'((32'(r_ptr) + k) % NR);
            if (!w_found && req_valid[w_scan_idx]) begin
                w_found                  = 1'b1;
                w_winner_idx             = w_scan_idx;
                w_winner_oh[w_scan_idx]  = 1'b1;
            end
        end
    end

    // Slot can take a new payload when empty or being drained this cycle.
    always_comb begin
        w_slot_free = (r_state == StIdle) || out_ready;
        w_accept    = w_slot_free && w_found && !rst;
        req_ready   = w_accept ? w_winner_oh : '0;
    end

    onehot_rr_arbiter_mux #(
        .N (NR),
        .W (DW)
    ) u_data_mux (
        .i_sel  (w_winner_oh),
        .i_data (req_data),
        .o_data (w_mux_data)
    );

    // Next-state: accept loads the slot, drain without request empties it.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_data_next  = r_data;
        w_grant_next = r_grant;
        if (w_accept) begin
            w_state_next = StFull;
            w_data_next  = w_mux_data;
            w_grant_next = w_winner_oh;
            w_ptr_next   = (w_winner_idx == PtrW'(NR - 1)) ? '0 : w_winner_idx + 1'b1;
        end else if (r_state == StFull && out_ready) begin
            w_state_next = StIdle;
            w_grant_next = '0;
        end
    end

    // State registers with synchronous reset that overrides any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_ptr   <= '0;
            r_data  <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_data  <= w_data_next;
            r_grant <= w_grant_next;
        end
    end

    assign out_valid = (r_state == StFull);
    assign out_data  = r_data;
    assign grant     = r_grant;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Directed self-checking bench for onehot_rr_arbiter with NR=4, DW=8.
module tb_onehot_rr_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*DW-1:0] req_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [NR-1:0]   grant;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    onehot_rr_arbiter #(
        .NR (NR),
        .DW (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle invariants on the handshake and grant encoding.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            assert ($onehot0(req_ready)) else begin
                errors++;
                $error("FAIL req_ready_onehot0: observed %b expected at most one bit", req_ready);
            end
            checks++;
            assert (out_valid ? $onehot(grant) : (grant == '0)) else begin
                errors++;
                $error("FAIL grant_vs_valid: observed grant %b valid %b expected onehot iff valid",
                       grant, out_valid);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        step();
        step();
        mon_en = 1'b1;
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_out_data", 32'(out_data), 32'h0);

        // Requests during reset are never acknowledged.
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("ready_in_reset", 32'(req_ready), 32'h0);
        step();

        // All valid, downstream always ready: rotate 0,1,2,3,0.
        rst = 1'b0;
        #1;
        check("first_ready_after_reset", 32'(req_ready), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_out_valid", 32'(out_valid), 32'h1);
            check("rr_grant", 32'(grant), 32'(4'b0001 << (i % 4)));
            check("rr_out_data", 32'(out_data), 32'h11 * ((i % 4) + 1));
        end

        // Drain with no request: slot empties.
        req_valid = '0;
        step();
        check("drain_out_valid", 32'(out_valid), 32'h0);
        check("drain_grant", 32'(grant), 32'h0);

        // Backpressure: requester 2 held while downstream stalls.
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 8'h5A;
        out_ready = 1'b0;
        #1;
        check("bp_ready_idle", 32'(req_ready), 32'b0100);
        step();
        for (int i = 0; i < 3; i++) begin
            check("bp_ready_stall", 32'(req_ready), 32'h0);
            check("bp_out_valid", 32'(out_valid), 32'h1);
            check("bp_out_data", 32'(out_data), 32'h5A);
            check("bp_grant", 32'(grant), 32'b0100);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_release", 32'(req_ready), 32'b0100);
        req_valid = '0;
        step();
        check("bp_drained", 32'(out_valid), 32'h0);

        // Wrap: grant requester 1 (ptr -> 2), then 0 and 1 valid -> 0 wins.
        req_valid = 4'b0010;
        #1;
        check("wrap_ready_1", 32'(req_ready), 32'b0010);
        step();
        check("wrap_grant_1", 32'(grant), 32'b0010);
        req_valid = 4'b0011;
        #1;
        check("wrap_ready_0", 32'(req_ready), 32'b0001);
        step();
        check("wrap_grant_0", 32'(grant), 32'b0001);
        check("wrap_data_0", 32'(out_data), 32'h11);

        // Reset while FULL clears the slot, then accepts immediately after.
        rst = 1'b1;
        #1;
        check("rst_full_ready", 32'(req_ready), 32'h0);
        step();
        check("rst_full_out_valid", 32'(out_valid), 32'h0);
        check("rst_full_grant", 32'(grant), 32'h0);
        check("rst_full_out_data", 32'(out_data), 32'h0);
        rst = 1'b0;
        req_valid = 4'b1000;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'b1000);
        step();
        check("post_rst_grant", 32'(grant), 32'b1000);
        check("post_rst_data", 32'(out_data), 32'h44);

        // Single requester streaming: one transfer per cycle, no bubble.
        req_valid = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            req_data[1*DW +: DW] = 8'(8'h60 + i);
            #1;
            check("stream_ready", 32'(req_ready), 32'b0010);
            step();
            check("stream_out_valid", 32'(out_valid), 32'h1);
            check("stream_grant", 32'(grant), 32'b0010);
            check("stream_data", 32'(out_data), 32'h60 + i);
        end

        req_valid = '0;
        step();
        check("final_idle", 32'(out_valid), 32'h0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
